fetch_sequencer: RTL

- Program-counter and fetch controller for the 8-bit NanoRisc instruction memory.
- Drives the memory address, captures the returned instruction byte and offers it to decode with a valid/ready handshake.
- Handles branch redirects, end-of-program detection and restart.
- Sits between the instruction memory (read on negedge, data stable by next posedge) and the decode stage.

---
 rtl/fetch_sequencer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Program counter and fetch controller: drives instruction memory, offers each byte to decode via valid/ready.
// Optional halt-word termination is enabled by defining FETCH_HALT_DETECT_EN.
module fetch_sequencer #(
    parameter int unsigned                ADDR_WIDTH = 8,
    parameter int unsigned                DATA_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0]      START_ADDR = '0,
    parameter logic [ADDR_WIDTH-1:0]      LAST_ADDR  = ADDR_WIDTH'(21),
    parameter logic [DATA_WIDTH-1:0]      HALT_WORD  = DATA_WIDTH'(8'hFF)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  inStart,
    input  logic [DATA_WIDTH-1:0] inInstruction,
    input  logic                  inReady,
    input  logic                  inBranchTaken,
    input  logic [ADDR_WIDTH-1:0] inBranchTarget,
    output logic [ADDR_WIDTH-1:0] outAddress,
    output logic [DATA_WIDTH-1:0] outInstruction,
    output logic                  outValid,
    output logic [ADDR_WIDTH-1:0] outPc,
    output logic                  outDone,
    output logic                  outError,
    output logic [7:0]            outIssueCount
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

`ifdef FETCH_HALT_DETECT_EN
    localparam logic HALT_EN = 1'b1;
`else
    localparam logic HALT_EN = 1'b0;
`endif

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [ADDR_WIDTH-1:0] out_pc_q, out_pc_d;
    logic                  valid_q, valid_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [7:0]            count_q, count_d;

    logic target_ok;
    logic halt_hit;

    assign target_ok = (inBranchTarget <= LAST_ADDR);
    assign halt_hit  = HALT_EN && (instr_q == HALT_WORD);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        out_pc_d = out_pc_q;
        valid_d  = valid_q;
        done_d   = done_q;
        error_d  = error_q;
        count_d  = count_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                valid_d = 1'b0;
                if (inStart) begin
                    pc_d    = START_ADDR;
                    count_d = '0;
                    error_d = 1'b0;
                    done_d  = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (inBranchTaken) begin
                    if (target_ok) begin
                        pc_d    = inBranchTarget;
                        state_d = S_FETCH;
                    end else begin
                        error_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end else begin
                    instr_d  = inInstruction;
                    out_pc_d = pc_q;
                    valid_d  = 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (inBranchTaken) begin
                    // Redirect discards the pending instruction without counting it.
                    valid_d = 1'b0;
                    if (target_ok) begin
                        pc_d    = inBranchTarget;
                        state_d = S_FETCH;
                    end else begin
                        error_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end else if (inReady) begin
                    valid_d = 1'b0;
                    count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
                    if (pc_q == LAST_ADDR || halt_hit) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        pc_d    = pc_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            instr_q  <= '0;
            out_pc_q <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            out_pc_q <= out_pc_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            error_q  <= error_d;
            count_q  <= count_d;
        end
    end

    // pc is itself a register, so the memory address is registered.
    assign outAddress     = pc_q;
    assign outInstruction = instr_q;
    assign outValid       = valid_q;
    assign outPc          = out_pc_q;
    assign outDone        = done_q;
    assign outError       = error_q;
    assign outIssueCount  = count_q;

endmodule
